// File: rtl/alink_pkg.sv
// Shared ALINK definitions: register map, STATE bit positions, command opcodes
// and the Wishbone master sequencing states.
package alink_pkg;

  localparam logic [5:0] REG_TXFIFO = 6'h00;
  localparam logic [5:0] REG_STATE  = 6'h04;
  localparam logic [5:0] REG_MASK   = 6'h08;
  localparam logic [5:0] REG_BUSY   = 6'h0c;
  localparam logic [5:0] REG_RXFIFO = 6'h10;

  localparam int STATE_TXFULL  = 0;
  localparam int STATE_FLUSH   = 1;
  localparam int STATE_RXEMPTY = 16;
  localparam int STATE_SCAN    = 31;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'd0,
    OP_READ   = 2'd1,
    OP_RXPOP  = 2'd2,
    OP_TXPUSH = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BUS  = 3'd1,
    ST_GAP  = 3'd2,
    ST_EVAL = 3'd3,
    ST_RESP = 3'd4
  } state_e;

endpackage

// File: rtl/alink_wb_xfer.sv
// Single Wishbone transaction engine: termination detect, STB timeout and
// read-data capture. The transaction runs for as long as 'active' is high.
module alink_wb_xfer #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        active,
  input  logic        we,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic [31:0] dat_i,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata
);

  logic [7:0] tmo_cnt;
  logic       tmo_hit;

  // Abort in the TIMEOUT-th STB cycle so STB is high exactly TIMEOUT cycles.
  assign tmo_hit = (tmo_cnt == 8'(TIMEOUT - 1));
  assign done    = active & (ack_i | err_i | tmo_hit);
  assign err     = active & (err_i | (tmo_hit & ~ack_i));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      rdata   <= '0;
    end else begin
      tmo_cnt <= (active & ~done) ? tmo_cnt + 8'd1 : 8'd0;
      if (active & ack_i & ~err_i & ~we)
        rdata <= dat_i;
    end
  end

endmodule

// File: rtl/alink_wb_master.sv
// Wishbone initiator for the ALINK register slave, driven by a command stream.
// Define ALINK_WB_MASTER_POLL_EN to enable the polled rx_pop / tx_push ops.
module alink_wb_master
  import alink_pkg::*;
#(
  parameter int TIMEOUT  = 255
`ifdef ALINK_WB_MASTER_POLL_EN
  ,
  parameter int POLL_MAX = 1023
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [5:0]  cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        ALINK_CYC_O,
  output logic        ALINK_STB_O,
  output logic        ALINK_WE_O,
  output logic [5:0]  ALINK_ADR_O,
  output logic [31:0] ALINK_DAT_O,
  output logic [3:0]  ALINK_SEL_O,
  output logic [2:0]  ALINK_CTI_O,
  output logic [1:0]  ALINK_BTE_O,
  output logic        ALINK_LOCK_O,
  input  logic        ALINK_ACK_I,
  input  logic        ALINK_ERR_I,
  input  logic        ALINK_RTY_I,
  input  logic [31:0] ALINK_DAT_I
);

  state_e      state, state_n;
  logic [5:0]  adr_r, adr_n;
  logic [31:0] dat_r, dat_n;
  logic        we_r, we_n;
  logic        err_r, err_n;
  logic        bus_r, bus_n;    // response data comes from the last captured read
  logic        stb, x_done, x_err;
  logic [31:0] rdata;
  logic        unused_rty;

`ifdef ALINK_WB_MASTER_POLL_EN
  logic [1:0]  op_r, op_n;
  logic        ph_r, ph_n;      // 0: polling STATE, 1: FIFO access
  logic [9:0]  pc_r, pc_n;
  logic        poll_ok;

  assign poll_ok = (op_r == OP_RXPOP) ? ~rdata[STATE_RXEMPTY] : ~rdata[STATE_TXFULL];
`endif

  assign unused_rty   = ALINK_RTY_I;
  assign stb          = (state == ST_BUS);
  assign ALINK_STB_O  = stb;
  assign ALINK_CYC_O  = stb;
  assign ALINK_WE_O   = stb & we_r;
  assign ALINK_ADR_O  = adr_r;
  assign ALINK_DAT_O  = dat_r;
  assign ALINK_SEL_O  = 4'hf;
  assign ALINK_CTI_O  = 3'd0;
  assign ALINK_BTE_O  = 2'd0;
  assign ALINK_LOCK_O = 1'b0;

  assign cmd_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign rsp_err   = err_r;
  assign rsp_dat   = bus_r ? rdata : 32'd0;

  alink_wb_xfer #(.TIMEOUT(TIMEOUT)) u_xfer (
    .clk    (clk),
    .rst    (rst),
    .active (stb),
    .we     (we_r),
    .ack_i  (ALINK_ACK_I),
    .err_i  (ALINK_ERR_I),
    .dat_i  (ALINK_DAT_I),
    .done   (x_done),
    .err    (x_err),
    .rdata  (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      adr_r <= '0;
      dat_r <= '0;
      we_r  <= 1'b0;
      err_r <= 1'b0;
      bus_r <= 1'b0;
`ifdef ALINK_WB_MASTER_POLL_EN
      op_r  <= '0;
      ph_r  <= 1'b0;
      pc_r  <= '0;
`endif
    end else begin
      state <= state_n;
      adr_r <= adr_n;
      dat_r <= dat_n;
      we_r  <= we_n;
      err_r <= err_n;
      bus_r <= bus_n;
`ifdef ALINK_WB_MASTER_POLL_EN
      op_r  <= op_n;
      ph_r  <= ph_n;
      pc_r  <= pc_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    adr_n   = adr_r;
    dat_n   = dat_r;
    we_n    = we_r;
    err_n   = err_r;
    bus_n   = bus_r;
`ifdef ALINK_WB_MASTER_POLL_EN
    op_n    = op_r;
    ph_n    = ph_r;
    pc_n    = pc_r;
`endif
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          dat_n = cmd_dat;
          err_n = 1'b0;
          bus_n = 1'b0;
          case (cmd_op)
            OP_WRITE: begin adr_n = cmd_adr; we_n = 1'b1; state_n = ST_BUS; end
            OP_READ:  begin adr_n = cmd_adr; we_n = 1'b0; state_n = ST_BUS; end
            default: begin
`ifdef ALINK_WB_MASTER_POLL_EN
              op_n    = cmd_op;
              adr_n   = REG_STATE;
              we_n    = 1'b0;
              ph_n    = 1'b0;
              pc_n    = '0;
              state_n = ST_BUS;
`else
              err_n   = 1'b1;
              state_n = ST_RESP;
`endif
            end
          endcase
        end
      end
      ST_BUS: begin
        if (x_done) begin
          if (x_err) begin
            err_n   = 1'b1;
            bus_n   = 1'b0;
            state_n = ST_RESP;
`ifdef ALINK_WB_MASTER_POLL_EN
          end else if ((op_r == OP_RXPOP || op_r == OP_TXPUSH) && !ph_r) begin
            pc_n    = pc_r + 10'd1;
            state_n = ST_GAP;
`endif
          end else begin
            bus_n   = ~we_r;
            state_n = ST_RESP;
          end
        end
      end
`ifdef ALINK_WB_MASTER_POLL_EN
      ST_GAP: state_n = ST_EVAL;
      ST_EVAL: begin
        if (poll_ok) begin
          ph_n    = 1'b1;
          adr_n   = (op_r == OP_RXPOP) ? REG_RXFIFO : REG_TXFIFO;
          we_n    = (op_r == OP_TXPUSH);
          state_n = ST_BUS;
        end else if (pc_r >= 10'(POLL_MAX)) begin
          // Report the last STATE value so the sequencer can see why it gave up.
          err_n   = 1'b1;
          bus_n   = 1'b1;
          state_n = ST_RESP;
        end else begin
          state_n = ST_BUS;
        end
      end
`endif
      ST_RESP: if (rsp_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alink_wb_master.sv
// Directed bench for alink_wb_master with a registered ALINK slave model.
// Compound-op vectors follow ALINK_WB_MASTER_POLL_EN.
module tb_alink_wb_master;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_adr;
  logic [31:0] cmd_dat, rsp_dat;
  logic        cyc, stb, we, lock;
  logic [5:0]  adr;
  logic [31:0] dat_o;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack = 1'b0, err = 1'b0, rty = 1'b0;
  logic [31:0] sdat = '0;

  alink_wb_master #(
    .TIMEOUT(8)
`ifdef ALINK_WB_MASTER_POLL_EN
    , .POLL_MAX(4)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .ALINK_CYC_O(cyc), .ALINK_STB_O(stb), .ALINK_WE_O(we), .ALINK_ADR_O(adr),
    .ALINK_DAT_O(dat_o), .ALINK_SEL_O(sel), .ALINK_CTI_O(cti), .ALINK_BTE_O(bte),
    .ALINK_LOCK_O(lock), .ALINK_ACK_I(ack), .ALINK_ERR_I(err), .ALINK_RTY_I(rty),
    .ALINK_DAT_I(sdat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave model knobs, driven from the test
  logic [31:0] busy = '0, rxd = '0;
  int          rxe = 0;
  logic        txf = 1'b0, sup = 1'b0, errf = 1'b0, clr = 1'b0;
  // Slave observations
  logic [31:0] mask = '0, txdat = '0;
  int          stb_hi = 0, rises = 0, acks = 0, sreads = 0, pops = 0, pushes = 0;
  logic        stb_q = 1'b0;
  int          cyc_bad = 0;

  always @(posedge clk) begin
    stb_q <= stb;
    if (clr) begin
      stb_hi <= 0; rises <= 0; acks <= 0; sreads <= 0; pops <= 0; pushes <= 0;
      ack <= 1'b0; err <= 1'b0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      if (stb) stb_hi <= stb_hi + 1;
      if (stb && !stb_q) rises <= rises + 1;
      if (stb && !ack && !err) begin
        if (errf) err <= 1'b1;
        else if (!sup) begin
          ack  <= 1'b1;
          acks <= acks + 1;
          if (we) begin
            if (adr == 6'h08) mask <= dat_o;
            if (adr == 6'h00) begin txdat <= dat_o; pushes <= pushes + 1; end
          end else begin
            case (adr)
              6'h04: begin
                sdat   <= {15'd0, (sreads < rxe), 15'd0, txf};
                sreads <= sreads + 1;
              end
              6'h08: sdat <= mask;
              6'h0c: sdat <= busy;
              6'h10: begin sdat <= rxd; pops <= pops + 1; end
              default: sdat <= '0;
            endcase
          end
        end
      end
    end
  end

  always @(negedge clk) if (cyc !== stb) cyc_bad++;

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [5:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic re);
    @(negedge clk);
    chk("cmd_ready_before", cmd_ready, 1);
    cmd_op = op; cmd_adr = a; cmd_dat = d; cmd_valid = 1'b1; clr = 1'b1;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      cmd_valid = 1'b0; clr = 1'b0;
      lat++;
    end while (!rsp_valid && lat < 200);
    if (!rsp_valid) begin
      errors++; checks++;
      $display("FAIL rsp_wait: no rsp_valid within %0d cycles", lat);
    end
    rd = rsp_dat; re = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("cmd_ready_after", cmd_ready, 1);
    chk("rsp_valid_after", rsp_valid, 0);
  endtask

  typedef struct {
    logic [1:0] op; logic [5:0] adr; logic [31:0] dat;
    logic [31:0] busy; logic [31:0] rxd; int rxe; logic txf; logic sup; logic errf;
    logic [31:0] edat; logic eerr; int elat; int ehi; int erise; int eacks;
    int esr; int epop; int epush;
  } vec_t;

  vec_t vt[$];

  initial begin
    int lat;
    logic [31:0] rd;
    logic re;
    int bad;

    cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_op = '0; cmd_adr = '0; cmd_dat = '0;
    rst = 1'b1;

    //        op   adr    dat           busy          rxd           rxe txf sup errf edat          eerr lat hi rise acks sr pop push
    vt.push_back('{2'd0, 6'h08, 32'hA5A5_0F0F, 32'h0,         32'h0,         0, 0, 0, 0, 32'h0,         0, 3, 2, 1, 1, 0, 0, 0});
    vt.push_back('{2'd1, 6'h0c, 32'h0,         32'h1234_5678, 32'h0,         0, 0, 0, 0, 32'h1234_5678, 0, 3, 2, 1, 1, 0, 0, 0});
    vt.push_back('{2'd1, 6'h08, 32'h0,         32'h0,         32'h0,         0, 0, 0, 0, 32'hA5A5_0F0F, 0, 3, 2, 1, 1, 0, 0, 0});
    vt.push_back('{2'd0, 6'h08, 32'h0000_0001, 32'h0,         32'h0,         0, 0, 0, 0, 32'h0,         0, 3, 2, 1, 1, 0, 0, 0});
    vt.push_back('{2'd1, 6'h08, 32'h0,         32'h0,         32'h0,         0, 0, 0, 0, 32'h0000_0001, 0, 3, 2, 1, 1, 0, 0, 0});
    vt.push_back('{2'd1, 6'h04, 32'h0,         32'h0,         32'h0,         0, 0, 0, 1, 32'h0,         1, 3, 2, 1, 0, 0, 0, 0});
    vt.push_back('{2'd1, 6'h0c, 32'h0,         32'h0,         32'h0,         0, 0, 1, 0, 32'h0,         1, 9, 8, 1, 0, 0, 0, 0});
    vt.push_back('{2'd1, 6'h0c, 32'h0,         32'h0BAD_F00D, 32'h0,         0, 0, 0, 0, 32'h0BAD_F00D, 0, 3, 2, 1, 1, 0, 0, 0});
`ifdef ALINK_WB_MASTER_POLL_EN
    vt.push_back('{2'd2, 6'h00, 32'h0,         32'h0,         32'hCAFE_0001, 3, 0, 0, 0, 32'hCAFE_0001, 0, 19, 10, 5, 5, 4, 1, 0});
    vt.push_back('{2'd3, 6'h00, 32'h55AA_55AA, 32'h0,         32'h0,         0, 1, 0, 0, 32'h0000_0001, 1, 17, 8, 4, 4, 4, 0, 0});
    vt.push_back('{2'd3, 6'h00, 32'h1357_2468, 32'h0,         32'h0,         0, 0, 0, 0, 32'h0,         0, 7, 4, 2, 2, 1, 0, 1});
`else
    vt.push_back('{2'd2, 6'h00, 32'h0,         32'h0,         32'hCAFE_0001, 0, 0, 0, 0, 32'h0,         1, 1, 0, 0, 0, 0, 0, 0});
    vt.push_back('{2'd3, 6'h00, 32'h1357_2468, 32'h0,         32'h0,         0, 0, 0, 0, 32'h0,         1, 1, 0, 0, 0, 0, 0, 0});
`endif

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stb", stb, 0);
    chk("rst_we", we, 0);
    chk("rst_adr", adr, 0);
    chk("rst_dat_o", dat_o, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_dat", rsp_dat, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("const_sel", sel, 4'hf);
    chk("const_cti_bte_lock", {cti, bte, lock}, 0);
    rst = 1'b0;

    foreach (vt[i]) begin
      busy = vt[i].busy; rxd = vt[i].rxd; rxe = vt[i].rxe; txf = vt[i].txf;
      sup = vt[i].sup; errf = vt[i].errf;
      do_cmd(vt[i].op, vt[i].adr, vt[i].dat, lat, rd, re);
      chk($sformatf("v%0d_dat", i), rd, vt[i].edat);
      chk($sformatf("v%0d_err", i), re, vt[i].eerr);
      chk($sformatf("v%0d_lat", i), lat, vt[i].elat);
      chk($sformatf("v%0d_stb_hi", i), stb_hi, vt[i].ehi);
      chk($sformatf("v%0d_stb_rises", i), rises, vt[i].erise);
      chk($sformatf("v%0d_acks", i), acks, vt[i].eacks);
      chk($sformatf("v%0d_state_reads", i), sreads, vt[i].esr);
      chk($sformatf("v%0d_rx_pops", i), pops, vt[i].epop);
      chk($sformatf("v%0d_tx_pushes", i), pushes, vt[i].epush);
    end
    sup = 1'b0; errf = 1'b0;
    chk("slave_mask", mask, 32'h0000_0001);
`ifdef ALINK_WB_MASTER_POLL_EN
    chk("slave_txdat", txdat, 32'h1357_2468);
`endif

    // Response is held while rsp_ready stays low
    busy = 32'h600D_CAFE;
    @(negedge clk);
    cmd_op = 2'd1; cmd_adr = 6'h0c; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("hold_rsp_valid", rsp_valid, 1);
    chk("hold_rsp_dat", rsp_dat, 32'h600D_CAFE);
    chk("hold_cmd_ready", cmd_ready, 0);
    chk("hold_stb", stb, 0);
    rsp_ready = 1'b1;
    @(negedge clk); rsp_ready = 1'b0;
    chk("hold_release", cmd_ready, 1);

    // Asynchronous reset while STB is high
    sup = 1'b1;
    @(negedge clk);
`ifdef ALINK_WB_MASTER_POLL_EN
    cmd_op = 2'd3; cmd_dat = 32'h7777_0000;
`else
    cmd_op = 2'd1; cmd_adr = 6'h0c;
`endif
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_stb_before", stb, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_stb_async", stb, 0);
    chk("mid_cyc_async", cyc, 0);
    chk("mid_ready_async", cmd_ready, 1);
    @(negedge clk); rst = 1'b0; sup = 1'b0;
    bad = 0;
    repeat (6) begin @(negedge clk); if (rsp_valid) bad++; end
    chk("mid_no_rsp", bad, 0);
    busy = 32'h0F0F_1234;
    do_cmd(2'd1, 6'h0c, 32'h0, lat, rd, re);
    chk("post_rst_dat", rd, 32'h0F0F_1234);
    chk("post_rst_err", re, 0);
    chk("post_rst_lat", lat, 3);

    chk("cyc_eq_stb", cyc_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
